// File: rtl/bl_order_gen_mc_pkg.sv
// Baseline order generator shared helpers.
// Width derivations used by the generator and its counters.
package bl_order_gen_mc_pkg;

  // Ceiling log2 usable in constant expressions.
  function automatic int log2c(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // A single channel still needs one bit.
  function automatic int chan_bits(input int c);
    return (c > 1) ? log2c(c) : 1;
  endfunction

  // Pairs covered by one rectangle pass.
  function automatic int bl_per_pass(input int n);
    return n * (n / 2 + 1);
  endfunction

endpackage

// File: rtl/bl_order_gen_mc_mod_ctr.sv
// Runtime-modulus up-counter with load and wrap flag.
// Wraps by comparing against last_i, never by bit overflow.
module bl_mod_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         inc_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign cnt_o  = cnt_q;
  assign wrap_o = (cnt_q == last_i);

  // Load wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (inc_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bl_order_gen_mc.sv
// Multi-channel rectangle-order baseline generator.
// BL_ORDER_GEN_MC_BL_IDX_EN adds the bl_idx pair index output.
module bl_order_gen_mc
  import bl_order_gen_mc_pkg::*;
#(
  parameter int N_ANTS  = 16,
  parameter int N_CHANS = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             sync,
  input  logic                             en,
  input  logic [log2c(N_ANTS):0]           n_ants_active,
  output logic [log2c(N_ANTS)-1:0]         ant_a,
  output logic [log2c(N_ANTS)-1:0]         ant_b,
  output logic [chan_bits(N_CHANS)-1:0]    chan,
  output logic                             buf_sel,
  output logic                             last_triangle,
  output logic                             valid,
  output logic                             pass_done,
  output logic                             frame_done,
  output logic                             cfg_err
`ifdef BL_ORDER_GEN_MC_BL_IDX_EN
  ,
  output logic [log2c(bl_per_pass(N_ANTS))-1:0] bl_idx
`endif
);

  localparam int AW = log2c(N_ANTS);
  localparam int NW = AW + 1;
  localparam int CW = chan_bits(N_CHANS);

  logic [NW-1:0] n_q, n_cur;
  logic          cfg_err_q;
  logic          legal;
  logic [AW-1:0] last_ant, half, off0;
  logic [AW-1:0] a, b, off;
  logic [CW-1:0] cc;
  logic          a_wrap, b_wrap, c_wrap;
  logic          step, same, eop;
  logic          bsel_q;

  logic [AW-1:0] ant_a_q, ant_b_q;
  logic [CW-1:0] chan_q;
  logic          buf_sel_q, tri_q, valid_q;
  logic          pd_q, fd_q;

  assign legal = !n_ants_active[0]
              && (n_ants_active >= NW'(2))
              && (n_ants_active <= NW'(N_ANTS));

  // During sync the new count must already drive the loads.
  assign n_cur    = sync ? (legal ? n_ants_active : NW'(N_ANTS))
                         : n_q;
  assign last_ant = AW'(n_cur - NW'(1));
  assign half     = AW'(n_cur >> 1);
  assign off0     = (half == last_ant) ? '0 : half + AW'(1);

  assign step = en && !sync;
  assign same = (a == b);
  assign eop  = step && a_wrap && b_wrap;

  bl_mod_ctr #(.W(AW)) u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_i     (sync || (step && same)),
    .ld_val_i (sync ? half : off),
    .inc_i    (step && !same),
    .last_i   (last_ant),
    .cnt_o    (a),
    .wrap_o   (a_wrap)
  );

  bl_mod_ctr #(.W(AW)) u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_i     (sync),
    .ld_val_i ('0),
    .inc_i    (step && same),
    .last_i   (last_ant),
    .cnt_o    (b),
    .wrap_o   (b_wrap)
  );

  bl_mod_ctr #(.W(AW)) u_off (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_i     (sync),
    .ld_val_i (off0),
    .inc_i    (step && same),
    .last_i   (last_ant),
    .cnt_o    (off),
    .wrap_o   ()
  );

  bl_mod_ctr #(.W(CW)) u_chan (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_i     (sync),
    .ld_val_i ('0),
    .inc_i    (eop),
    .last_i   (CW'(N_CHANS - 1)),
    .cnt_o    (cc),
    .wrap_o   (c_wrap)
  );

  // Latch the active antenna count and its legality on sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q       <= NW'(N_ANTS);
      cfg_err_q <= 1'b0;
    end else if (sync) begin
      n_q       <= n_cur;
      cfg_err_q <= !legal;
    end
  end

  // Buffer select flips once per completed pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   bsel_q <= 1'b0;
    else if (sync) bsel_q <= 1'b0;
    else if (eop)  bsel_q <= !bsel_q;
  end

  // Register the consumed pair; hold fields when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ant_a_q   <= '0;
      ant_b_q   <= '0;
      chan_q    <= '0;
      buf_sel_q <= 1'b0;
      tri_q     <= 1'b0;
      valid_q   <= 1'b0;
      pd_q      <= 1'b0;
      fd_q      <= 1'b0;
    end else if (step) begin
      ant_a_q   <= a;
      ant_b_q   <= b;
      chan_q    <= cc;
      buf_sel_q <= (a <= b) ? bsel_q : !bsel_q;
      tri_q     <= (a > b);
      valid_q   <= 1'b1;
      pd_q      <= eop;
      fd_q      <= eop && c_wrap;
    end else begin
      valid_q   <= 1'b0;
    end
  end

  assign ant_a         = ant_a_q;
  assign ant_b         = ant_b_q;
  assign chan          = chan_q;
  assign buf_sel       = buf_sel_q;
  assign last_triangle = tri_q;
  assign valid         = valid_q;
  assign pass_done     = pd_q;
  assign frame_done    = fd_q;
  assign cfg_err       = cfg_err_q;

`ifdef BL_ORDER_GEN_MC_BL_IDX_EN
  localparam int IW = log2c(bl_per_pass(N_ANTS));

  logic [IW-1:0] idx_q, idx_out_q;

  // Position within the pass; restarts on sync and wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      idx_out_q <= '0;
    end else if (sync) begin
      idx_q     <= '0;
    end else if (step) begin
      idx_out_q <= idx_q;
      idx_q     <= eop ? '0 : idx_q + IW'(1);
    end
  end

  assign bl_idx = idx_out_q;
`endif

endmodule

// File: tb/tb_bl_order_gen_mc.sv
// Directed bench for bl_order_gen_mc.
// Two instances: N_ANTS=4/N_CHANS=8 and N_ANTS=16/N_CHANS=2.
module tb_bl_order_gen_mc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic       a_sync = 0, a_en = 0;
  logic [2:0] a_n = 0;
  logic [1:0] a_ant_a, a_ant_b;
  logic [2:0] a_chan;
  logic       a_bs, a_tri, a_val, a_pd, a_fd, a_err;

  logic       b_sync = 0, b_en = 0;
  logic [4:0] b_n = 0;
  logic [3:0] b_ant_a, b_ant_b;
  logic [0:0] b_chan;
  logic       b_bs, b_tri, b_val, b_pd, b_fd, b_err;

`ifdef BL_ORDER_GEN_MC_BL_IDX_EN
  logic [3:0] a_idx;
  logic [7:0] b_idx;
`endif

  bl_order_gen_mc #(.N_ANTS(4), .N_CHANS(8)) dut_a (
    .clk           (clk),
    .rst_n         (rst_n),
    .sync          (a_sync),
    .en            (a_en),
    .n_ants_active (a_n),
    .ant_a         (a_ant_a),
    .ant_b         (a_ant_b),
    .chan          (a_chan),
    .buf_sel       (a_bs),
    .last_triangle (a_tri),
    .valid         (a_val),
    .pass_done     (a_pd),
    .frame_done    (a_fd),
    .cfg_err       (a_err)
`ifdef BL_ORDER_GEN_MC_BL_IDX_EN
    ,
    .bl_idx        (a_idx)
`endif
  );

  bl_order_gen_mc #(.N_ANTS(16), .N_CHANS(2)) dut_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .sync          (b_sync),
    .en            (b_en),
    .n_ants_active (b_n),
    .ant_a         (b_ant_a),
    .ant_b         (b_ant_b),
    .chan          (b_chan),
    .buf_sel       (b_bs),
    .last_triangle (b_tri),
    .valid         (b_val),
    .pass_done     (b_pd),
    .frame_done    (b_fd),
    .cfg_err       (b_err)
`ifdef BL_ORDER_GEN_MC_BL_IDX_EN
    ,
    .bl_idx        (b_idx)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  int ea[12] = '{2,3,0,3,0,1,0,1,2,1,2,3};
  int eb[12] = '{0,0,0,1,1,1,2,2,2,3,3,3};
  int et[12] = '{1,1,0,1,0,0,0,0,0,0,0,0};
  int e6[4]  = '{3,4,5,0};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full n=4 pass on dut_a; p selects the bsel parity.
  task automatic pass_a(input int p, input int ch);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("A.valid", a_val, 1);
      chk("A.ant_a", a_ant_a, ea[i]);
      chk("A.ant_b", a_ant_b, eb[i]);
      chk("A.tri", a_tri, et[i]);
      chk("A.pass_done", a_pd, (i == 11));
      chk("A.frame_done", a_fd, 0);
      chk("A.chan", a_chan, ch);
      chk("A.buf_sel", a_bs, et[i] ^ (p % 2));
    end
  endtask

  initial begin
    logic [31:0] pat;
    int idx;
    int fd_cnt;

    #2;
    chk("rst.A.valid", a_val, 0);
    chk("rst.A.ant_a", a_ant_a, 0);
    chk("rst.A.buf_sel", a_bs, 0);
    chk("rst.A.cfg_err", a_err, 0);
    chk("rst.B.pass_done", b_pd, 0);
    @(negedge clk);
    rst_n = 1'b1;

    a_n = 3'd4;
    a_sync = 1;
    tick();
    chk("A.sync.valid", a_val, 0);
    chk("A.sync.cfg_err", a_err, 0);
    a_sync = 0;
    a_en = 1;
    pass_a(0, 0);
    pass_a(1, 1);

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("A.p3.chan", a_chan, 2);
      chk("A.p3.ant_a", a_ant_a, ea[i]);
    end
    a_sync = 1;
    tick();
    chk("A.abort.valid", a_val, 0);
    a_sync = 0;
    pass_a(0, 0);

    a_en = 0;
    tick();
    chk("A.idle.valid", a_val, 0);
    chk("A.idle.ant_a", a_ant_a, 3);

    a_sync = 1;
    tick();
    a_sync = 0;
    pat = 32'b1011_0010_1110_0101_1001_1101_0110_1011;
    idx = 0;
    for (int c = 0; c < 32; c++) begin
      a_en = pat[c];
      tick();
      if (pat[c]) begin
        chk("A.tog.valid", a_val, 1);
        chk("A.tog.ant_a", a_ant_a, ea[idx % 12]);
        chk("A.tog.ant_b", a_ant_b, eb[idx % 12]);
        chk("A.tog.chan", a_chan, idx / 12);
        chk("A.tog.pd", a_pd, (idx % 12 == 11));
        chk("A.tog.buf_sel", a_bs, et[idx % 12] ^ ((idx / 12) % 2));
        idx++;
      end else begin
        chk("A.tog.valid0", a_val, 0);
      end
    end
    a_en = 0;
    chk("A.tog.count", idx, 19);

    b_n = 5'd6;
    b_sync = 1;
    tick();
    b_sync = 0;
    b_en = 1;
    b_n = 5'd8;
    fd_cnt = 0;
    for (int i = 0; i < 96; i++) begin
      tick();
      if (i < 4) chk("B.ant_a", b_ant_a, e6[i]);
      chk("B.valid", b_val, 1);
      chk("B.pd", b_pd, (i % 24 == 23));
      chk("B.fd", b_fd, (i % 48 == 47));
      chk("B.chan", b_chan, (i / 24) % 2);
      if (b_fd) fd_cnt++;
    end
    chk("B.fd_count", fd_cnt, 2);

    b_n = 5'd5;
    b_sync = 1;
    tick();
    chk("B.cfg_err5", b_err, 1);
    b_sync = 0;
    tick();
    chk("B.n16.ant_a", b_ant_a, 8);
    chk("B.n16.ant_b", b_ant_b, 0);
    tick();
    chk("B.n16.ant_a2", b_ant_a, 9);
    chk("B.cfg_hold", b_err, 1);

    b_n = 5'd6;
    b_sync = 1;
    tick();
    chk("B.cfg_clr", b_err, 0);
    b_sync = 0;
    tick();
    tick();
    tick();
    chk("B.pre_rst.ant_a", b_ant_a, 5);
    chk("B.pre_rst.valid", b_val, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.B.valid", b_val, 0);
    chk("arst.B.ant_a", b_ant_a, 0);
    chk("arst.A.ant_a", a_ant_a, 0);
    chk("arst.A.chan", a_chan, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
